// File: rtl/ahb_cmd_master_if.sv
// Command/response stream plus AHB-Lite initiator signals bundled for ahb_cmd_master.
interface ahb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hmastlock;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
           hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
           hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite SINGLE-transfer initiator driven by a valid/ready command stream.
// Optional macro AHB_CMD_MASTER_ALIGN_CHECK_EN rejects misaligned commands instead of aligning them.
module ahb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  ahb_cmd_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic [ADDR_WIDTH-1:0] haddr_reg;
  logic [1:0]            htrans_reg;
  logic                  hwrite_reg;
  logic [2:0]            hsize_reg;
  logic [DATA_WIDTH-1:0] hwdata_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic                  cmd_legal;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] rd_lane;

  // Misaligned low address bits are dropped so the bus always sees a naturally aligned transfer.
  always_comb begin
    aligned_addr = bus.cmd_addr;
    if (bus.cmd_size == 3'd1) begin
      aligned_addr[0] = 1'b0;
    end else if (bus.cmd_size == 3'd2) begin
      aligned_addr[1:0] = 2'b00;
    end
  end

`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
  assign cmd_legal = (bus.cmd_size <= 3'd2) && (aligned_addr == bus.cmd_addr);
`else
  assign cmd_legal = (bus.cmd_size <= 3'd2);
`endif

  always_comb begin
    case (bus.cmd_size)
      3'd0:    wdata_rep = {4{bus.cmd_wdata[7:0]}};
      3'd1:    wdata_rep = {2{bus.cmd_wdata[15:0]}};
      default: wdata_rep = bus.cmd_wdata;
    endcase
  end

  // Read lane select uses the aligned address actually driven on haddr.
  always_comb begin
    rd_shifted = bus.hrdata >> {haddr_reg[1:0], 3'b000};
    case (hsize_reg)
      3'd0:    rd_lane = {24'd0, rd_shifted[7:0]};
      3'd1:    rd_lane = {16'd0, rd_shifted[15:0]};
      default: rd_lane = rd_shifted;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      haddr_reg     <= '0;
      htrans_reg    <= HTRANS_IDLE;
      hwrite_reg    <= 1'b0;
      hsize_reg     <= 3'd0;
      hwdata_reg    <= '0;
      wdata_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_ready_reg && bus.cmd_valid) begin
            cmd_ready_reg <= 1'b0;
            if (cmd_legal) begin
              haddr_reg  <= aligned_addr;
              hwrite_reg <= bus.cmd_write;
              hsize_reg  <= bus.cmd_size;
              wdata_reg  <= wdata_rep;
              htrans_reg <= HTRANS_NONSEQ;
              state_reg  <= S_ADDR;
            end else begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (bus.hready) begin
            htrans_reg <= HTRANS_IDLE;
            hwdata_reg <= wdata_reg;
            state_reg  <= S_DATA;
          end
        end
        S_DATA: begin
          // The first ERROR cycle has hready low, so only the completing cycle lands here.
          if (bus.hready) begin
            rsp_err_reg   <= bus.hresp;
            rsp_rdata_reg <= (!hwrite_reg && !bus.hresp) ? rd_lane : '0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.haddr     = haddr_reg;
  assign bus.htrans    = htrans_reg;
  assign bus.hwrite    = hwrite_reg;
  assign bus.hsize     = hsize_reg;
  assign bus.hwdata    = hwdata_reg;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Self-checking bench for ahb_cmd_master: directed vector table, reset corner cases, randomized traffic vs. a reference model.
module tb_ahb_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();
  ahb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.CLK(clk), .RST(rst), .bus(bus_if));

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          aw;
    int          dw;
    logic        err;
    int          bp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_haddr;
    logic [31:0] exp_hwdata;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Reference: derived from transfer rules (sizes in bytes, lane arithmetic), not from any FSM.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int nb;
    logic legal;
    logic [31:0] aligned, hw;
    logic [63:0] mask;
    legal = (v.size <= 3'd2);
    nb = legal ? (1 << v.size) : 1;
`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
    if (legal && (v.addr % nb) != 0) legal = 1'b0;
`endif
    aligned = v.addr - (v.addr % nb);
    for (int b = 0; b < 4; b++) hw[8*b +: 8] = v.wdata[8*(b % nb) +: 8];
    mask = (64'd1 << (8*nb)) - 64'd1;
    r.exp_haddr  = aligned;
    r.exp_hwdata = hw;
    r.exp_err    = !legal || v.err;
    r.exp_rdata  = (legal && !v.wr && !v.err) ? ((v.hrdata >> (8*(aligned % 4))) & mask[31:0]) : 32'h0;
    r.exp_lat    = legal ? (3 + v.aw + v.dw + (v.err ? 1 : 0)) : 1;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Issues one command (called at a negedge), acts as the AHB slave, then handles response backpressure.
  task automatic run_txn(input vec_t v);
    int lat = 0, acnt = 0, dcnt = 0, nonseq = 0;
    bit accepted = 0, done = 0, in_data = 0, go_data, acc_now;
    bit a_unstable = 0, d_unstable = 0, bp_bad = 0, legal;
    logic [31:0] s_haddr = 0, s_hwdata = 0, g_rdata = 0;
    logic s_hwrite = 0, g_err = 0;
    logic [2:0] s_hsize = 0;
    legal = (v.exp_lat != 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = v.wr;
    bus_if.cmd_addr  = v.addr;
    bus_if.cmd_size  = v.size;
    bus_if.cmd_wdata = v.wdata;
    bus_if.rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (accepted && bus_if.rsp_valid) begin
        done = 1; g_rdata = bus_if.rsp_rdata; g_err = bus_if.rsp_err;
        break;
      end
      bus_if.hready = 1'b1; bus_if.hresp = 1'b0; bus_if.hrdata = 32'h0;
      if (bus_if.htrans == 2'b10) nonseq++;
      if (in_data) begin
        if (dcnt == 0) s_hwdata = bus_if.hwdata;
        else if (bus_if.hwdata !== s_hwdata) d_unstable = 1;
        if (dcnt < v.dw) bus_if.hready = 1'b0;
        else if (v.err && dcnt == v.dw) begin bus_if.hready = 1'b0; bus_if.hresp = 1'b1; end
        else begin bus_if.hresp = v.err; bus_if.hrdata = v.hrdata; end
        dcnt++;
      end else if (bus_if.htrans == 2'b10) begin
        if (acnt == 0) begin
          s_haddr = bus_if.haddr; s_hwrite = bus_if.hwrite; s_hsize = bus_if.hsize;
        end else if (bus_if.haddr !== s_haddr || bus_if.hwrite !== s_hwrite || bus_if.hsize !== s_hsize) begin
          a_unstable = 1;
        end
        bus_if.hready = (acnt >= v.aw);
        acnt++;
      end
      go_data = !in_data && bus_if.htrans == 2'b10 && bus_if.hready;
      acc_now = !accepted && bus_if.cmd_valid && bus_if.cmd_ready;
      @(posedge clk);
      if (accepted || acc_now) lat++;
      if (acc_now) accepted = 1;
      if (go_data) in_data = 1;
      @(negedge clk);
      if (acc_now) bus_if.cmd_valid = 1'b0;
    end
    bus_if.hready = 1'b1; bus_if.hresp = 1'b0; bus_if.cmd_valid = 1'b0;
    if (!done) begin
      chk({v.name, "/timeout"}, 32'd0, 32'd1);
      pulse_reset();
      return;
    end
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== g_rdata ||
          bus_if.rsp_err !== g_err || bus_if.cmd_ready !== 1'b0) bp_bad = 1;
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    $display("txn %s: wr=%0d addr=%h size=%0d -> rdata=%h err=%0d lat=%0d",
             v.name, v.wr, v.addr, v.size, g_rdata, g_err, lat);
    chk({v.name, "/rsp_err"}, g_err, v.exp_err);
    chk({v.name, "/rsp_rdata"}, g_rdata, v.exp_rdata);
    chk({v.name, "/latency"}, lat, v.exp_lat);
    chk({v.name, "/nonseq_cycles"}, nonseq, legal ? v.aw + 1 : 0);
    if (legal) begin
      chk({v.name, "/haddr"}, s_haddr, v.exp_haddr);
      chk({v.name, "/hwrite"}, s_hwrite, v.wr);
      chk({v.name, "/hsize"}, s_hsize, v.size);
      chk({v.name, "/addr_stable"}, a_unstable, 0);
      chk({v.name, "/hwdata_stable"}, d_unstable, 0);
      if (v.wr) chk({v.name, "/hwdata"}, s_hwdata, v.exp_hwdata);
    end
    if (v.bp > 0) chk({v.name, "/backpressure_hold"}, bp_bad, 0);
    chk({v.name, "/post_handshake"}, {bus_if.rsp_valid, bus_if.cmd_ready}, 2'b01);
  endtask

  // Drives a word write up to the chosen phase, then asserts RST between clock edges.
  task automatic reset_mid(input bit in_data_phase);
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h400;
    bus_if.cmd_size = 3'd2; bus_if.cmd_wdata = 32'h5A5AA5A5; bus_if.hready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("rst_mid/pre_nonseq", bus_if.htrans, 2'b10);
    if (in_data_phase) begin
      @(posedge clk); @(negedge clk);
      chk("rst_mid/pre_hwdata", bus_if.hwdata, 32'h5A5AA5A5);
    end
    bus_if.hready = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("txn rst_mid: phase=%s htrans=%b rsp_valid=%0d hwdata=%h",
             in_data_phase ? "DATA" : "ADDR", bus_if.htrans, bus_if.rsp_valid, bus_if.hwdata);
    chk("rst_mid/htrans", bus_if.htrans, 2'b00);
    chk("rst_mid/rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("rst_mid/cmd_ready", bus_if.cmd_ready, 1'b0);
    chk("rst_mid/haddr_hwdata", {bus_if.haddr | bus_if.hwdata}, 32'h0);
    @(negedge clk);
    rst = 1'b0; bus_if.hready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid/cmd_ready_after", bus_if.cmd_ready, 1'b1);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 32'h0;
    bus_if.cmd_size = 3'd0; bus_if.cmd_wdata = 32'h0; bus_if.rsp_ready = 1'b0;
    bus_if.hrdata = 32'h0; bus_if.hready = 1'b1; bus_if.hresp = 1'b0;

    //          name        wr    addr        sz    wdata          hrdata         aw dw err   bp  rdata          err   lat haddr        hwdata
    tbl[0] = '{"wr_word",   1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 0,  32'h0,        1'b0, 3, 32'h100, 32'hDEADBEEF};
    tbl[1] = '{"rd_byte3",  1'b0, 32'h103, 3'd0, 32'h0,        32'hA1B2C3D4, 0, 0, 1'b0, 0,  32'h000000A1, 1'b0, 3, 32'h103, 32'h0};
    tbl[2] = '{"wr_half",   1'b1, 32'h102, 3'd1, 32'h1234,     32'h0,        0, 0, 1'b0, 0,  32'h0,        1'b0, 3, 32'h102, 32'h12341234};
    tbl[3] = '{"rd_waits",  1'b0, 32'h200, 3'd2, 32'h0,        32'h11223344, 2, 3, 1'b0, 0,  32'h11223344, 1'b0, 8, 32'h200, 32'h0};
    tbl[4] = '{"rd_error",  1'b0, 32'h300, 3'd2, 32'h0,        32'hFFFFFFFF, 0, 0, 1'b1, 0,  32'h0,        1'b1, 4, 32'h300, 32'h0};
`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
    tbl[5] = '{"rd_misalgn",1'b0, 32'h102, 3'd2, 32'h0,        32'hCAFEF00D, 0, 0, 1'b0, 0,  32'h0,        1'b1, 1, 32'h0,   32'h0};
`else
    tbl[5] = '{"rd_misalgn",1'b0, 32'h102, 3'd2, 32'h0,        32'hCAFEF00D, 0, 0, 1'b0, 0,  32'hCAFEF00D, 1'b0, 3, 32'h100, 32'h0};
`endif
    tbl[6] = '{"size3",     1'b0, 32'h100, 3'd3, 32'h0,        32'h12345678, 0, 0, 1'b0, 0,  32'h0,        1'b1, 1, 32'h0,   32'h0};
    tbl[7] = '{"rd_bp10",   1'b0, 32'h102, 3'd1, 32'h0,        32'hA1B2C3D4, 0, 0, 1'b0, 10, 32'h0000A1B2, 1'b0, 3, 32'h102, 32'h0};
    tbl[8] = '{"wr_err_w",  1'b1, 32'h500, 3'd0, 32'h77,       32'h0,        1, 1, 1'b1, 0,  32'h0,        1'b1, 6, 32'h500, 32'h77777777};
    tbl[9] = '{"rd_byte1",  1'b0, 32'h101, 3'd0, 32'h0,        32'hA1B2C3D4, 0, 2, 1'b0, 1,  32'h000000C3, 1'b0, 5, 32'h101, 32'h0};

    #3;
    chk("reset/cmd_ready", bus_if.cmd_ready, 1'b0);
    chk("reset/rsp", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, 32'h0);
    chk("reset/htrans", bus_if.htrans, 2'b00);
    chk("reset/haddr_hwdata", {bus_if.haddr | bus_if.hwdata}, 32'h0);
    chk("reset/hwrite_hsize", {bus_if.hwrite, bus_if.hsize}, 4'h0);
    chk("reset/consts", {bus_if.hburst, bus_if.hprot, bus_if.hmastlock}, 8'b000_0011_0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("reset/cmd_ready_after", bus_if.cmd_ready, 1'b1);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    reset_mid(1'b1);
    run_txn(tbl[0]);
    reset_mid(1'b0);
    run_txn(tbl[3]);

    for (int i = 0; i < 40; i++) begin
      rv.name   = "rand";
      rv.wr     = 1'($urandom_range(0, 1));
      rv.addr   = $urandom & 32'h0000_0FFF;
      rv.size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rv.wdata  = $urandom;
      rv.hrdata = $urandom;
      rv.aw     = $urandom_range(0, 2);
      rv.dw     = $urandom_range(0, 2);
      rv.err    = ($urandom_range(0, 5) == 0);
      rv.bp     = $urandom_range(0, 2);
      run_txn(model(rv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
